// File: rtl/main_memory_pipelined.sv
// Pipelined main-memory model: one word request per cycle, read data returned
// a fixed LATENCY cycles after issue with a one-cycle valid strobe.
module main_memory_pipelined #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 2 ** (ADDR_WIDTH - 1),
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic [3:0]            pending
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [15:0]        mem [DEPTH];
  logic [IDX_W-1:0]   word_idx;
  logic               rd_req;
  logic               wr_req;

  logic [LATENCY-1:0] pipe_valid;
  logic [15:0]        pipe_data [LATENCY];
  logic [LATENCY-1:0] stage_in_valid;
  logic [15:0]        stage_in_data [LATENCY];

  assign word_idx = addr[IDX_W:1];
  assign rd_req   = enable & ~wr;
  assign wr_req   = enable & wr & rst_n;

  // Array contents survive reset; only the request path is gated by rst_n.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem[word_idx] <= data_in;
    end
  end

  // Stage 0 snapshots the array at issue; later stages take the previous stage.
  genvar g;
  generate
    for (g = 0; g < LATENCY; g++) begin : g_stage_in
      if (g == 0) begin : g_first
        assign stage_in_valid[g] = rd_req;
        assign stage_in_data[g]  = mem[word_idx];
      end else begin : g_rest
        assign stage_in_valid[g] = pipe_valid[g-1];
        assign stage_in_data[g]  = pipe_data[g-1];
      end
    end
  endgenerate

  // Data only moves with a valid token, so the last stage holds the last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= stage_in_valid[i];
        if (stage_in_valid[i]) begin
          pipe_data[i] <= stage_in_data[i];
        end
      end
    end
  end

  // A read stays counted through its strobe cycle and retires on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'd0;
    end else begin
      pending <= pending + {3'b000, rd_req} - {3'b000, pipe_valid[LATENCY-1]};
    end
  end

  assign data_valid = pipe_valid[LATENCY-1];
  assign data_out   = pipe_data[LATENCY-1];

endmodule
